// File: rtl/decode_queue.sv
// ============================================================================
//  Module   : decode_queue
//  Brief    : RV32I decode stage with valid/ready on both sides and a
//             DEPTH-entry queue of decoded bundles between fetch and exec.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module decode_queue #(
   parameter int         XLEN       = 32,
   parameter int         DEPTH      = 2,
   parameter logic [6:0] OUT_OPCODE = 7'b0000001
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             flush,
   input  logic                             in_valid,
   output logic                             in_ready,
   input  logic [31:0]                      in_instr,
   input  logic [XLEN-1:0]                  in_pc,
   output logic                             out_valid,
   input  logic                             out_ready,
   output logic [XLEN-1:0]                  out_pc,
   output logic [XLEN-1:0]                  out_imm,
   output logic [4:0]                       out_alu_ctl,
   output logic [4:0]                       out_rs1,
   output logic [4:0]                       out_rs2,
   output logic [4:0]                       out_rd,
   output logic                             out_branch_c,
   output logic                             out_branch_uc,
   output logic                             out_branch_relative,
   output logic                             out_mem_read,
   output logic                             out_mem_write,
   output logic                             out_alu_pc,
   output logic                             out_alu_src,
   output logic                             out_reg_write,
   output logic                             out_data_out,
   output logic                             out_illegal,
   output logic [$clog2(DEPTH+1)-1:0]       count
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   // Major opcodes
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   // ALU operation codes
   localparam logic [4:0] ALU_AND  = 5'd0;
   localparam logic [4:0] ALU_OR   = 5'd1;
   localparam logic [4:0] ALU_ADD  = 5'd2;
   localparam logic [4:0] ALU_XOR  = 5'd3;
   localparam logic [4:0] ALU_SLL  = 5'd4;
   localparam logic [4:0] ALU_SRL  = 5'd5;
   localparam logic [4:0] ALU_SUB  = 5'd6;
   localparam logic [4:0] ALU_LT   = 5'd7;
   localparam logic [4:0] ALU_GE   = 5'd8;
   localparam logic [4:0] ALU_CHB  = 5'd10;
   localparam logic [4:0] ALU_EQ   = 5'd11;
   localparam logic [4:0] ALU_NE   = 5'd12;
   localparam logic [4:0] ALU_LTU  = 5'd13;
   localparam logic [4:0] ALU_GEU  = 5'd14;
   localparam logic [4:0] ALU_SRA  = 5'd15;
   localparam logic [4:0] ALU_ZERO = 5'd31;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] imm;
      logic [4:0]      alu_ctl;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [4:0]      rd;
      logic            branch_c;
      logic            branch_uc;
      logic            branch_relative;
      logic            mem_read;
      logic            mem_write;
      logic            alu_pc;
      logic            alu_src;
      logic            reg_write;
      logic            data_out;
      logic            illegal;
   } bundle_t;

   bundle_t          mem_q [DEPTH];
   logic [PW-1:0]    head_q, head_d;
   logic [PW-1:0]    tail_q, tail_d;
   logic [CW-1:0]    count_q, count_d;

   bundle_t          w_dec;
   bundle_t          w_head;
   logic             w_ill;
   logic             w_push;
   logic             w_pop;

   logic [6:0]       w_opc;
   logic [2:0]       w_f3;
   logic [6:0]       w_f7;
   logic [XLEN-1:0]  w_imm_i;
   logic [XLEN-1:0]  w_imm_s;
   logic [XLEN-1:0]  w_imm_b;
   logic [XLEN-1:0]  w_imm_u;
   logic [XLEN-1:0]  w_imm_j;

   assign w_opc = in_instr[6:0];
   assign w_f3  = in_instr[14:12];
   assign w_f7  = in_instr[31:25];

   assign w_imm_i = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
   assign w_imm_s = {{(XLEN-12){in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
   assign w_imm_b = {{(XLEN-12){in_instr[31]}}, in_instr[7], in_instr[30:25],
                     in_instr[11:8], 1'b0};
   assign w_imm_u = {{(XLEN-31){in_instr[31]}}, in_instr[30:12], 12'b0};
   assign w_imm_j = {{(XLEN-20){in_instr[31]}}, in_instr[19:12], in_instr[20],
                     in_instr[30:21], 1'b0};

   // Pointer advance, wrapping modulo DEPTH (DEPTH need not fill PW bits when 1)
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   // Combinational decode of the incoming instruction into a bundle
   always_comb begin
      w_dec     = '0;
      w_ill     = 1'b0;
      w_dec.pc  = in_pc;
      w_dec.rs1 = in_instr[19:15];
      w_dec.rs2 = in_instr[24:20];
      w_dec.rd  = in_instr[11:7];
      if (w_opc == OUT_OPCODE) begin
         // Custom output opcode: only data_out is raised
         w_dec.data_out = 1'b1;
      end else begin
         case (w_opc)
            OPC_LUI: begin
               w_dec.imm             = w_imm_u;
               w_dec.alu_ctl         = ALU_CHB;
               w_dec.alu_src         = 1'b1;
               w_dec.reg_write       = 1'b1;
               w_dec.branch_relative = 1'b1;
            end
            OPC_AUIPC: begin
               w_dec.imm             = w_imm_u;
               w_dec.alu_ctl         = ALU_ADD;
               w_dec.alu_pc          = 1'b1;
               w_dec.alu_src         = 1'b1;
               w_dec.reg_write       = 1'b1;
               w_dec.branch_relative = 1'b1;
            end
            OPC_JAL: begin
               w_dec.imm             = w_imm_j;
               w_dec.alu_ctl         = ALU_CHB;
               w_dec.branch_uc       = 1'b1;
               w_dec.branch_relative = 1'b1;
               w_dec.alu_pc          = 1'b1;
               w_dec.alu_src         = 1'b1;
               w_dec.reg_write       = 1'b1;
            end
            OPC_JALR: begin
               w_ill                 = (w_f3 != 3'b000);
               w_dec.imm             = w_imm_i;
               w_dec.alu_ctl         = ALU_ADD;
               w_dec.branch_uc       = 1'b1;
               w_dec.alu_src         = 1'b1;
               w_dec.reg_write       = 1'b1;
            end
            OPC_BRANCH: begin
               w_dec.imm             = w_imm_b;
               w_dec.branch_c        = 1'b1;
               w_dec.branch_relative = 1'b1;
               case (w_f3)
                  3'b000:  w_dec.alu_ctl = ALU_EQ;
                  3'b001:  w_dec.alu_ctl = ALU_NE;
                  3'b100:  w_dec.alu_ctl = ALU_LT;
                  3'b101:  w_dec.alu_ctl = ALU_GE;
                  3'b110:  w_dec.alu_ctl = ALU_LTU;
                  3'b111:  w_dec.alu_ctl = ALU_GEU;
                  default: w_ill         = 1'b1;
               endcase
            end
            OPC_LOAD: begin
               w_ill                 = (w_f3 != 3'b010);
               w_dec.imm             = w_imm_i;
               w_dec.alu_ctl         = ALU_ADD;
               w_dec.mem_read        = 1'b1;
               w_dec.alu_src         = 1'b1;
               w_dec.reg_write       = 1'b1;
               w_dec.branch_relative = 1'b1;
            end
            OPC_STORE: begin
               w_ill                 = (w_f3 != 3'b010);
               w_dec.imm             = w_imm_s;
               w_dec.alu_ctl         = ALU_ADD;
               w_dec.mem_write       = 1'b1;
               w_dec.alu_src         = 1'b1;
               w_dec.branch_relative = 1'b1;
            end
            OPC_OPIMM: begin
               w_dec.imm             = w_imm_i;
               w_dec.alu_src         = 1'b1;
               w_dec.reg_write       = 1'b1;
               w_dec.branch_relative = 1'b1;
               case (w_f3)
                  3'b000: w_dec.alu_ctl = ALU_ADD;
                  3'b010: w_dec.alu_ctl = ALU_LT;
                  3'b011: w_dec.alu_ctl = ALU_LTU;
                  3'b100: w_dec.alu_ctl = ALU_XOR;
                  3'b110: w_dec.alu_ctl = ALU_OR;
                  3'b111: w_dec.alu_ctl = ALU_AND;
                  3'b001: begin
                     w_dec.alu_ctl = ALU_SLL;
                     w_ill         = (w_f7 != F7_BASE);
                  end
                  default: begin
                     // 3'b101: srli / srai chosen by funct7
                     if (w_f7 == F7_BASE)     w_dec.alu_ctl = ALU_SRL;
                     else if (w_f7 == F7_ALT) w_dec.alu_ctl = ALU_SRA;
                     else                     w_ill         = 1'b1;
                  end
               endcase
            end
            OPC_OP: begin
               w_dec.reg_write       = 1'b1;
               w_dec.branch_relative = 1'b1;
               if (w_f7 == F7_BASE) begin
                  case (w_f3)
                     3'b000:  w_dec.alu_ctl = ALU_ADD;
                     3'b001:  w_dec.alu_ctl = ALU_SLL;
                     3'b010:  w_dec.alu_ctl = ALU_LT;
                     3'b011:  w_dec.alu_ctl = ALU_LTU;
                     3'b100:  w_dec.alu_ctl = ALU_XOR;
                     3'b101:  w_dec.alu_ctl = ALU_SRL;
                     3'b110:  w_dec.alu_ctl = ALU_OR;
                     default: w_dec.alu_ctl = ALU_AND;
                  endcase
               end else if (w_f7 == F7_ALT && w_f3 == 3'b000) begin
                  w_dec.alu_ctl = ALU_SUB;
               end else if (w_f7 == F7_ALT && w_f3 == 3'b101) begin
                  w_dec.alu_ctl = ALU_SRA;
               end else begin
                  w_ill = 1'b1;
               end
            end
            default: w_ill = 1'b1;
         endcase
      end

      if (w_ill) begin
         // Illegal encodings carry no side effects downstream
         w_dec.imm             = '0;
         w_dec.alu_ctl         = ALU_ZERO;
         w_dec.branch_c        = 1'b0;
         w_dec.branch_uc       = 1'b0;
         w_dec.branch_relative = 1'b0;
         w_dec.mem_read        = 1'b0;
         w_dec.mem_write       = 1'b0;
         w_dec.alu_pc          = 1'b0;
         w_dec.alu_src         = 1'b0;
         w_dec.reg_write       = 1'b0;
         w_dec.data_out        = 1'b0;
         w_dec.illegal         = 1'b1;
      end else if (w_dec.rd == 5'd0) begin
         // Writes to x0 are architecturally discarded
         w_dec.reg_write = 1'b0;
      end
   end

   // Handshake qualifiers; in_ready depends only on registered state
   assign in_ready  = (count_q < CW'(DEPTH));
   assign out_valid = (count_q != '0);
   assign w_push    = in_valid && in_ready;
   assign w_pop     = out_valid && out_ready;

   // Next-state for pointers and occupancy; flush discards push and pop
   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (flush) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         if (w_push) tail_d = ptr_inc(tail_q);
         if (w_pop)  head_d = ptr_inc(head_q);
         case ({w_push, w_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // Pointer and occupancy registers
   always_ff @(posedge clk) begin
      if (rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Bundle storage: decoded instruction written at the tail on push
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (w_push && !flush) begin
         mem_q[tail_q] <= w_dec;
      end
   end

   assign w_head = mem_q[head_q];

   assign out_pc              = w_head.pc;
   assign out_imm             = w_head.imm;
   assign out_alu_ctl         = w_head.alu_ctl;
   assign out_rs1             = w_head.rs1;
   assign out_rs2             = w_head.rs2;
   assign out_rd              = w_head.rd;
   assign out_branch_c        = w_head.branch_c;
   assign out_branch_uc       = w_head.branch_uc;
   assign out_branch_relative = w_head.branch_relative;
   assign out_mem_read        = w_head.mem_read;
   assign out_mem_write       = w_head.mem_write;
   assign out_alu_pc          = w_head.alu_pc;
   assign out_alu_src         = w_head.alu_src;
   assign out_reg_write       = w_head.reg_write;
   assign out_data_out        = w_head.data_out;
   assign out_illegal         = w_head.illegal;
   assign count               = count_q;

endmodule

`default_nettype wire

// File: tb/tb_decode_queue.sv
// ============================================================================
//  Module   : tb_decode_queue
//  Brief    : Scoreboard bench for decode_queue (XLEN=32, DEPTH=2).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_decode_queue;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_instr;
   logic [31:0] in_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   logic [31:0] out_imm;
   logic [4:0]  out_alu_ctl;
   logic [4:0]  out_rs1;
   logic [4:0]  out_rs2;
   logic [4:0]  out_rd;
   logic        out_branch_c;
   logic        out_branch_uc;
   logic        out_branch_relative;
   logic        out_mem_read;
   logic        out_mem_write;
   logic        out_alu_pc;
   logic        out_alu_src;
   logic        out_reg_write;
   logic        out_data_out;
   logic        out_illegal;
   logic [1:0]  count;

   always #5 clk = ~clk;

   decode_queue #(.XLEN(32), .DEPTH(2), .OUT_OPCODE(7'b0000001)) dut (
      .clk                 (clk),
      .rst                 (rst),
      .flush               (flush),
      .in_valid            (in_valid),
      .in_ready            (in_ready),
      .in_instr            (in_instr),
      .in_pc               (in_pc),
      .out_valid           (out_valid),
      .out_ready           (out_ready),
      .out_pc              (out_pc),
      .out_imm             (out_imm),
      .out_alu_ctl         (out_alu_ctl),
      .out_rs1             (out_rs1),
      .out_rs2             (out_rs2),
      .out_rd              (out_rd),
      .out_branch_c        (out_branch_c),
      .out_branch_uc       (out_branch_uc),
      .out_branch_relative (out_branch_relative),
      .out_mem_read        (out_mem_read),
      .out_mem_write       (out_mem_write),
      .out_alu_pc          (out_alu_pc),
      .out_alu_src         (out_alu_src),
      .out_reg_write       (out_reg_write),
      .out_data_out        (out_data_out),
      .out_illegal         (out_illegal),
      .count               (count)
   );

   // Expected decode per instruction; fl = {bc,buc,brel,mrd,mwr,apc,asrc,rw,dout,ill}
   typedef struct {
      logic [31:0] instr;
      logic [31:0] imm;
      logic [4:0]  alu;
      logic [9:0]  fl;
      bit          ci;
   } vec_t;

   typedef struct {
      int          idx;
      logic [31:0] pc;
   } sb_t;

   vec_t        tbl [16];
   sb_t         sb [$];
   int          n_total = 0;
   int          n_bad   = 0;
   int          cur_idx = 0;
   logic [31:0] cur_pc  = '0;
   bit          acc;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=0x%08h expected=0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic offer(input int idx, input logic [31:0] pc);
      in_valid = 1'b1;
      in_instr = tbl[idx].instr;
      in_pc    = pc;
      cur_idx  = idx;
      cur_pc   = pc;
   endtask

   task automatic compare_head(input sb_t e);
      vec_t        v;
      logic [9:0]  fl;
      v  = tbl[e.idx];
      fl = {out_branch_c, out_branch_uc, out_branch_relative, out_mem_read,
            out_mem_write, out_alu_pc, out_alu_src, out_reg_write,
            out_data_out, out_illegal};
      check("pc",    out_pc,      e.pc);
      check("alu",   32'(out_alu_ctl), 32'(v.alu));
      check("flags", 32'(fl),     32'(v.fl));
      check("rs1",   32'(out_rs1), 32'(v.instr[19:15]));
      check("rs2",   32'(out_rs2), 32'(v.instr[24:20]));
      check("rd",    32'(out_rd),  32'(v.instr[11:7]));
      if (v.ci) check("imm", out_imm, v.imm);
   endtask

   // One clock: sample just after the negedge drive, score, then advance
   task automatic step(output bit accepted);
      sb_t e;
      #1;
      check("count",    32'(count),     32'(sb.size()));
      check("in_ready", 32'(in_ready),  32'(sb.size() < 2));
      check("out_valid",32'(out_valid), 32'(sb.size() != 0));
      accepted = in_valid && in_ready && !flush;
      if (!flush && out_valid && sb.size() != 0) begin
         e = sb[0];
         if (out_ready) begin
            compare_head(e);
            void'(sb.pop_front());
         end else begin
            check("stall_pc", out_pc, e.pc);
         end
      end
      if (accepted) sb.push_back('{cur_idx, cur_pc});
      if (flush) sb.delete();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      tbl[0]  = '{32'hFFF00293, 32'hFFFFFFFF, 5'd2,  10'b0010001100, 1'b1}; // addi x5,x0,-1
      tbl[1]  = '{32'h123450B7, 32'h12345000, 5'd10, 10'b0010001100, 1'b1}; // lui x1,0x12345
      tbl[2]  = '{32'h00000013, 32'h00000000, 5'd2,  10'b0010001000, 1'b1}; // addi x0,x0,0
      tbl[3]  = '{32'h0000007F, 32'h00000000, 5'd31, 10'b0000000001, 1'b0}; // bad opcode
      tbl[4]  = '{32'h00000001, 32'h00000000, 5'd0,  10'b0000000010, 1'b0}; // output opcode
      tbl[5]  = '{32'h002081B3, 32'h00000000, 5'd2,  10'b0010000100, 1'b0}; // add x3,x1,x2
      tbl[6]  = '{32'h40208233, 32'h00000000, 5'd6,  10'b0010000100, 1'b0}; // sub x4,x1,x2
      tbl[7]  = '{32'h00812303, 32'h00000008, 5'd2,  10'b0011001100, 1'b1}; // lw x6,8(x2)
      tbl[8]  = '{32'hFE512E23, 32'hFFFFFFFC, 5'd2,  10'b0010101000, 1'b1}; // sw x5,-4(x2)
      tbl[9]  = '{32'hFE208CE3, 32'hFFFFFFF8, 5'd11, 10'b1010000000, 1'b1}; // beq x1,x2,-8
      tbl[10] = '{32'h010000EF, 32'h00000010, 5'd10, 10'b0110011100, 1'b1}; // jal x1,16
      tbl[11] = '{32'h00008067, 32'h00000000, 5'd2,  10'b0100001000, 1'b1}; // jalr x0,0(x1)
      tbl[12] = '{32'hFFFFF397, 32'hFFFFF000, 5'd2,  10'b0010011100, 1'b1}; // auipc x7,0xFFFFF
      tbl[13] = '{32'h4034D413, 32'h00000403, 5'd15, 10'b0010001100, 1'b1}; // srai x8,x9,3
      tbl[14] = '{32'h02208233, 32'h00000000, 5'd31, 10'b0000000001, 1'b0}; // bad funct7
      tbl[15] = '{32'h00811303, 32'h00000000, 5'd31, 10'b0000000001, 1'b0}; // lh (bad width)
   end

   initial begin
      int          k;
      bit          pending;
      logic [31:0] pc;

      rst       = 1'b1;
      flush     = 1'b0;
      in_valid  = 1'b0;
      in_instr  = '0;
      in_pc     = '0;
      out_ready = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      // Reset state
      #1;
      check("rst_count",     32'(count),         32'd0);
      check("rst_out_valid", 32'(out_valid),     32'd0);
      check("rst_in_ready",  32'(in_ready),      32'd1);
      check("rst_imm",       out_imm,            32'd0);
      check("rst_alu",       32'(out_alu_ctl),   32'd0);
      check("rst_pc",        out_pc,             32'd0);
      check("rst_rw",        32'(out_reg_write), 32'd0);
      @(negedge clk);

      // Single push with latency one
      offer(0, 32'h100);
      step(acc);
      check("t1_acc", 32'(acc), 32'd1);
      in_valid = 1'b0;
      #1;
      check("t1_out_valid", 32'(out_valid), 32'd1);
      out_ready = 1'b1;
      step(acc);
      out_ready = 1'b0;

      // Fill with exec stalled; third instruction is held back
      offer(1, 32'h104);
      step(acc);
      check("t2_acc1", 32'(acc), 32'd1);
      offer(2, 32'h108);
      step(acc);
      check("t2_acc2", 32'(acc), 32'd1);
      offer(3, 32'h10C);
      step(acc);
      check("t2_held", 32'(acc), 32'd0);
      out_ready = 1'b1;
      for (int c = 0; c < 4 && !acc; c++) step(acc);
      check("t2_acc3", 32'(acc), 32'd1);
      in_valid = 1'b0;
      for (int c = 0; c < 4 && sb.size() != 0; c++) step(acc);

      // Steady push+pop at count=1 across pointer wrap
      out_ready = 1'b0;
      offer(4, 32'h200);
      step(acc);
      out_ready = 1'b1;
      for (int c = 0; c < 4; c++) begin
         offer(5 + c, 32'h204 + 32'(4 * c));
         step(acc);
         check("t3_acc", 32'(acc), 32'd1);
      end
      in_valid = 1'b0;
      step(acc);

      // Flush with a full queue and a pending push
      out_ready = 1'b0;
      offer(9, 32'h300);
      step(acc);
      offer(10, 32'h304);
      step(acc);
      offer(11, 32'h308);
      flush     = 1'b1;
      out_ready = 1'b1;
      step(acc);
      flush    = 1'b0;
      in_valid = 1'b0;
      #1;
      check("fl_count",     32'(count),     32'd0);
      check("fl_out_valid", 32'(out_valid), 32'd0);
      check("fl_in_ready",  32'(in_ready),  32'd1);
      repeat (2) step(acc);

      // Remaining encodings back to back
      for (int c = 12; c < 16; c++) begin
         offer(c, 32'h400 + 32'(4 * c));
         step(acc);
         check("t5_acc", 32'(acc), 32'd1);
      end
      in_valid = 1'b0;
      step(acc);

      // Randomised traffic with occasional flushes
      k       = 0;
      pending = 1'b0;
      pc      = 32'h1000;
      for (int c = 0; c < 400; c++) begin
         if (!pending) begin
            if ($urandom_range(0, 3) != 0) begin
               offer(k, pc);
               pending = 1'b1;
            end else begin
               in_valid = 1'b0;
            end
         end
         out_ready = ($urandom_range(0, 2) != 0);
         flush     = ($urandom_range(0, 40) == 0);
         step(acc);
         if (pending && (acc || flush)) begin
            k       = (k + 1) % 16;
            pc      = pc + 32'd4;
            pending = 1'b0;
         end
      end
      flush     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int c = 0; c < 8 && sb.size() != 0; c++) step(acc);
      check("drain_empty", 32'(sb.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
